// File: rtl/pixel_write_queue.sv
// Pixel write queue: buffers renderer pixel strobes in a small FIFO and drains
// them into the shared frame-buffer write port whenever the arbiter grants it.
module pixel_write_queue #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] FB_WORDS = 32'd76800,
  parameter logic [31:0] FB_BASE  = 32'h0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      flush,
  input  logic [31:0]               pixel_data,
  input  logic [31:0]               pixel_addr,
  input  logic                      pixel_write,
  output logic                      pixel_full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      fb_req,
  input  logic                      fb_gnt,
  output logic [31:0]               fb_addr,
  output logic [31:0]               fb_wdata,
  output logic                      fb_we,
  output logic                      ovf,
  input  logic                      ovf_clr,
  output logic [15:0]               clip_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [63:0] mem [DEPTH];
  logic [63:0] head;

  logic empty;
  logic full;
  logic in_range;
  logic pop;
  logic push;
  logic clip;
  logic overflow;

  // A flush cycle swallows the incoming pixel entirely: no store, no clip
  // count and no overflow flag, and the head is not written out.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    in_range = (pixel_addr < FB_WORDS);
    pop      = ce & ~empty & fb_gnt & ~flush;
    push     = ce & ~flush & pixel_write & in_range & (~full | pop);
    clip     = ce & ~flush & pixel_write & ~in_range;
    overflow = ce & ~flush & pixel_write & in_range & full & ~pop;
    head     = mem[rd_ptr[AW-1:0]];
  end

  assign pixel_full = full;
  assign level      = wr_ptr - rd_ptr;
  assign fb_req     = ~empty;
  assign fb_we      = pop;
  assign fb_addr    = head[63:32];
  assign fb_wdata   = head[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      clip_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (ce && flush)
        rd_ptr <= wr_ptr;
      else if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (overflow)
        ovf <= 1'b1;
      else if (ce && ovf_clr)
        ovf <= 1'b0;
      if (clip && (clip_cnt != '1))
        clip_cnt <= clip_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {pixel_addr + FB_BASE, pixel_data};
  end

endmodule
